control_direccion: RTL and testbench
====================================

// Module: control_direccion
// PURPOSE
//  Consumes the 3-bit button code from the input stage (0 none, 1 arriba, 2 abajo,
//  3 izquierda, 4 derecha, 5 pausa). Turns code changes into single press events.
//  Holds the snake's current and pending heading, and blocks 180-degree reversals.
//  Toggles pause, and generates the periodic movement tick `paso` that drives the
//  snake update logic downstream.
// PARAMETERS
//  TICKS_PASO   6250000  clk cycles per movement step (>= 2)
//  DIR_INICIAL  4        heading after reset (1..4)
// PORTS
//  clk          in   1   system clock, rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  boton_pres   in   3   registered button code from input stage
//  direccion    out  3   applied heading, always 1..4
//  pausado      out  1   1 = game paused
//  paso         out  1   one-cycle pulse: advance snake one cell
//  cambio_dir   out  1   one-cycle pulse coincident with paso when direccion changed
// BEHAVIOUR
//  Interface: one clock (clk); reset_n is asynchronous and active-low.
//  Reset (async, immediate):
//   - direccion = dir_pend = DIR_INICIAL.
//   - pausado = 0, paso = 0, cambio_dir = 0.
//   - cuenta = 0, codigo_prev = 0.
//  Press detection:
//   - codigo_prev <= boton_pres every cycle.
//   - Event when boton_pres != codigo_prev and boton_pres != 0.
//   - Held code produces exactly one event. Codes 6 and 7 never produce events.
//  Direction event (code 1..4), accepted only when pausado == 0:
//   - Rejected if the code is the opposite of the APPLIED direccion (1<->2, 3<->4),
//     not the opposite of dir_pend.
//   - Otherwise dir_pend <= code. A later accepted event before the step overwrites it.
//  Pause event (code 5):
//   - pausado <= ~pausado.
//   - Direction events while pausado == 1 are discarded; dir_pend is unchanged.
//  Step counter:
//   - cuenta has width $clog2(TICKS_PASO).
//   - While pausado == 0: increments each cycle, range 0..TICKS_PASO-1.
//   - While pausado == 1: holds its value. Unpausing resumes the count from there.
//  Step, on the edge where cuenta == TICKS_PASO-1 and pausado (current value) == 0:
//   - cuenta <= 0, paso <= 1, direccion <= dir_pend.
//   - cambio_dir <= (dir_pend != direccion).
//   - paso and cambio_dir are registered and are 0 on every other cycle.
//   - New direccion is visible in the same cycle paso is high.
//  Simultaneous events:
//   - Pause event on a step edge: the step still occurs; pausado toggles on the same edge.
//   - Direction event on a step edge: the old dir_pend is applied and the new code
//     becomes dir_pend for the next step. The reversal check uses the pre-edge direccion.
//  Latency: press event -> dir_pend update is 1 cycle after the code changes at the
//   input. dir_pend -> direccion waits for the next step.
//  Reset mid-count or mid-pause returns all state to reset values at once; no partial step.
// TESTING (TICKS_PASO=4, DIR_INICIAL=4)
//  1. Release reset, boton_pres=0 -> direccion=4, pausado=0, paso high on clk 4, 8, 12
//     after release; cambio_dir never high.
//  2. boton_pres=1 held 10 clks starting mid-period -> direccion=1 at the next paso
//     with cambio_dir=1 once; no further cambio_dir while still held.
//  3. direccion=4, press 3 -> rejected; direccion stays 4 on following paso, cambio_dir=0.
//  4. direccion=4, press 1 then press 3 within one period -> 3 accepted (opposite of 4?
//     no: opposite of 4 is 3, so rejected); dir_pend stays 1; next paso gives direccion=1.
//  5. Press 5 at cuenta=1 -> pausado=1, no paso for 20 clks, press 2 ignored.
//     Press 5 again -> pausado=0, paso after 2 more clks, direccion unchanged.
//  6. Drop reset_n at cuenta=2 with dir_pend=2 -> outputs at reset values before the
//     next edge; after release direccion=4 and first paso on clk 4.

Source files
------------

// File: rtl/control_direccion_if.sv
// -----------------------------------------------------------------------------
// control_direccion_if
//   Groups the button code coming from the input stage with the heading, pause
//   and movement-step signals that control_direccion hands to the snake update
//   logic.
//
//   Signals
//     boton_pres  [2:0]  registered button code (0 none, 1 arriba, 2 abajo,
//                        3 izquierda, 4 derecha, 5 pausa)
//     direccion   [2:0]  applied heading, always 1..4
//     pausado            1 = game paused
//     paso               one-cycle pulse: advance the snake one cell
//     cambio_dir         one-cycle pulse with paso when the heading changed
//
//   Modports
//     master  side that produces the button code and consumes the outputs
//     slave   control_direccion itself
// -----------------------------------------------------------------------------
interface control_direccion_if;
  logic [2:0] boton_pres;
  logic [2:0] direccion;
  logic       pausado;
  logic       paso;
  logic       cambio_dir;

  modport master (
    output boton_pres,
    input  direccion,
    input  pausado,
    input  paso,
    input  cambio_dir
  );

  modport slave (
    input  boton_pres,
    output direccion,
    output pausado,
    output paso,
    output cambio_dir
  );
endinterface

// File: rtl/control_direccion.sv
// -----------------------------------------------------------------------------
// control_direccion
//   Turns the button code from the input stage into single press events, keeps
//   the snake's applied and pending heading (blocking 180-degree reversals),
//   toggles pause, and generates the periodic movement step `paso`.
//
//   Parameters
//     TICKS_PASO   clk cycles per movement step (>= 2)
//     DIR_INICIAL  heading after reset (1..4)
//
//   Ports
//     clk      in   system clock, rising edge
//     reset_n  in   asynchronous, active-low reset
//     bus      slave modport of control_direccion_if
//                boton_pres in; direccion, pausado, paso, cambio_dir out
// -----------------------------------------------------------------------------
module control_direccion #(
  parameter int TICKS_PASO  = 6250000,
  parameter int DIR_INICIAL = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  control_direccion_if.slave   bus
);

  localparam int             CW         = (TICKS_PASO > 1) ? $clog2(TICKS_PASO) : 1;
  localparam logic [CW-1:0]  CUENTA_MAX = CW'(TICKS_PASO - 1);
  localparam logic [2:0]     DIR_RST    = 3'(DIR_INICIAL);

  localparam logic [2:0] COD_NADA  = 3'd0;
  localparam logic [2:0] COD_ARR   = 3'd1;
  localparam logic [2:0] COD_ABA   = 3'd2;
  localparam logic [2:0] COD_IZQ   = 3'd3;
  localparam logic [2:0] COD_DER   = 3'd4;
  localparam logic [2:0] COD_PAUSA = 3'd5;

  typedef enum logic {
    EST_JUEGO = 1'b0,
    EST_PAUSA = 1'b1
  } estado_t;

  // Heading that would be a 180-degree reversal of `d`.
  function automatic logic [2:0] opuesto(input logic [2:0] d);
    logic [2:0] r;
    r = COD_NADA;
    case (d)
      COD_ARR: r = COD_ABA;
      COD_ABA: r = COD_ARR;
      COD_IZQ: r = COD_DER;
      COD_DER: r = COD_IZQ;
      default: r = COD_NADA;
    endcase
    return r;
  endfunction

  function automatic logic es_direccion(input logic [2:0] c);
    return (c >= COD_ARR) && (c <= COD_DER);
  endfunction

  estado_t       estado, estado_sig;
  logic [CW-1:0] cuenta, cuenta_sig;
  logic [2:0]    codigo_prev;
  logic [2:0]    dir_pend, dir_pend_sig;
  logic [2:0]    direccion, direccion_sig;
  logic          paso, paso_sig;
  logic          cambio_dir, cambio_sig;

  logic          evento;
  logic          ev_pausa;
  logic          ev_dir;
  logic          fin_periodo;

  // A press is a change of code towards a non-zero value; holding a key
  // therefore yields a single event. Codes 6 and 7 are ignored outright.
  assign evento      = (bus.boton_pres != codigo_prev) && (bus.boton_pres != COD_NADA);
  assign ev_pausa    = evento && (bus.boton_pres == COD_PAUSA);
  assign ev_dir      = evento && es_direccion(bus.boton_pres);
  assign fin_periodo = (estado == EST_JUEGO) && (cuenta == CUENTA_MAX);

  // ---- state register ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado      <= EST_JUEGO;
      cuenta      <= '0;
      codigo_prev <= COD_NADA;
      dir_pend    <= DIR_RST;
      direccion   <= DIR_RST;
      paso        <= 1'b0;
      cambio_dir  <= 1'b0;
    end else begin
      estado      <= estado_sig;
      cuenta      <= cuenta_sig;
      codigo_prev <= bus.boton_pres;
      dir_pend    <= dir_pend_sig;
      direccion   <= direccion_sig;
      paso        <= paso_sig;
      cambio_dir  <= cambio_sig;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    estado_sig    = estado;
    cuenta_sig    = cuenta;
    dir_pend_sig  = dir_pend;
    direccion_sig = direccion;
    paso_sig      = 1'b0;
    cambio_sig    = 1'b0;

    // Pause toggles on every pause press, including one landing on a step edge;
    // the step itself is decided from the pre-edge pause state.
    if (ev_pausa) begin
      estado_sig = (estado == EST_JUEGO) ? EST_PAUSA : EST_JUEGO;
    end

    // The counter freezes while paused so unpausing resumes the period.
    if (estado == EST_JUEGO) begin
      if (fin_periodo) begin
        cuenta_sig = '0;
      end else begin
        cuenta_sig = cuenta + CW'(1);
      end
    end

    // On a step the pending heading becomes the applied one. A direction press
    // on the same edge still sees the pre-edge dir_pend here and is queued
    // below for the following step.
    if (fin_periodo) begin
      direccion_sig = dir_pend;
      paso_sig      = 1'b1;
      cambio_sig    = (dir_pend != direccion);
    end

    // Reversal is judged against the applied heading, not the pending one, so
    // e.g. derecha -> arriba -> izquierda within one period keeps arriba.
    if (ev_dir && (estado == EST_JUEGO) && (bus.boton_pres != opuesto(direccion))) begin
      dir_pend_sig = bus.boton_pres;
    end
  end

  assign bus.direccion  = direccion;
  assign bus.pausado    = (estado == EST_PAUSA);
  assign bus.paso       = paso;
  assign bus.cambio_dir = cambio_dir;

endmodule

// File: tb/tb_control_direccion.sv
module tb_control_direccion;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  control_direccion_if bus ();

  control_direccion #(
    .TICKS_PASO  (4),
    .DIR_INICIAL (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset_n        = 1'b0;
    bus.boton_pres = 3'd0;

    // Reset state
    ticks(2);
    check("rst_dir",    8'(bus.direccion),  8'd4);
    check("rst_pausa",  8'(bus.pausado),    8'd0);
    check("rst_paso",   8'(bus.paso),       8'd0);
    check("rst_cambio", 8'(bus.cambio_dir), 8'd0);
    reset_n = 1'b1;

    // 1: free-running steps on edges 4, 8, 12
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("t1_paso_e%0d", k),   8'(bus.paso),       8'((k % 4) == 0));
      check($sformatf("t1_cambio_e%0d", k), 8'(bus.cambio_dir), 8'd0);
      check($sformatf("t1_dir_e%0d", k),    8'(bus.direccion),  8'd4);
    end

    // 2: arriba held 10 clocks starting mid-period (after edge 14, cuenta=2)
    ticks(2);
    bus.boton_pres = 3'd1;
    for (int k = 15; k <= 24; k++) begin
      tick();
      check($sformatf("t2_paso_e%0d", k),   8'(bus.paso),       8'((k % 4) == 0));
      check($sformatf("t2_cambio_e%0d", k), 8'(bus.cambio_dir), 8'(k == 16));
      check($sformatf("t2_dir_e%0d", k),    8'(bus.direccion),  (k >= 16) ? 8'd1 : 8'd4);
    end

    // Back to derecha: press 4 at edge 25, applied on edge 28
    bus.boton_pres = 3'd4;
    tick();
    bus.boton_pres = 3'd0;
    ticks(3);
    check("t3_pre_paso",   8'(bus.paso),       8'd1);
    check("t3_pre_dir",    8'(bus.direccion),  8'd4);
    check("t3_pre_cambio", 8'(bus.cambio_dir), 8'd1);

    // 3: izquierda against derecha is rejected
    bus.boton_pres = 3'd3;
    tick();
    bus.boton_pres = 3'd0;
    ticks(3);
    check("t3_paso",   8'(bus.paso),       8'd1);
    check("t3_dir",    8'(bus.direccion),  8'd4);
    check("t3_cambio", 8'(bus.cambio_dir), 8'd0);

    // 4: arriba then izquierda in one period; izquierda reverses applied derecha
    bus.boton_pres = 3'd1;
    tick();
    bus.boton_pres = 3'd3;
    tick();
    bus.boton_pres = 3'd0;
    ticks(2);
    check("t4_paso",   8'(bus.paso),       8'd1);
    check("t4_dir",    8'(bus.direccion),  8'd1);
    check("t4_cambio", 8'(bus.cambio_dir), 8'd1);

    // 5: pause at cuenta=1 (after edge 37), press 38 toggles pause
    tick();
    bus.boton_pres = 3'd5;
    tick();
    check("t5_pausado", 8'(bus.pausado), 8'd1);
    bus.boton_pres = 3'd0;
    for (int k = 39; k <= 58; k++) begin
      tick();
      if (k == 39) bus.boton_pres = 3'd3;
      if (k == 40) bus.boton_pres = 3'd0;
      check($sformatf("t5_nopaso_e%0d", k), 8'(bus.paso),    8'd0);
      check($sformatf("t5_pausa_e%0d", k),  8'(bus.pausado), 8'd1);
    end
    bus.boton_pres = 3'd5;
    tick();
    check("t5_unpause", 8'(bus.pausado), 8'd0);
    check("t5_paso0",   8'(bus.paso),    8'd0);
    bus.boton_pres = 3'd0;
    tick();
    check("t5_paso1", 8'(bus.paso), 8'd0);
    tick();
    check("t5_paso2",   8'(bus.paso),       8'd1);
    check("t5_dir",     8'(bus.direccion),  8'd1);
    check("t5_cambio",  8'(bus.cambio_dir), 8'd0);

    // 6: set direccion=3, then dir_pend=2, then reset at cuenta=2
    bus.boton_pres = 3'd3;
    tick();
    bus.boton_pres = 3'd0;
    ticks(3);
    check("t6_dir3",    8'(bus.direccion),  8'd3);
    check("t6_cambio3", 8'(bus.cambio_dir), 8'd1);
    bus.boton_pres = 3'd2;
    tick();
    bus.boton_pres = 3'd0;
    tick();
    reset_n = 1'b0;
    #1;
    check("t6_rst_dir",    8'(bus.direccion),  8'd4);
    check("t6_rst_pausa",  8'(bus.pausado),    8'd0);
    check("t6_rst_paso",   8'(bus.paso),       8'd0);
    check("t6_rst_cambio", 8'(bus.cambio_dir), 8'd0);
    ticks(2);
    reset_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("t6_paso_e%0d", k), 8'(bus.paso),      8'(k == 4));
      check($sformatf("t6_dir_e%0d", k),  8'(bus.direccion), 8'd4);
    end
    check("t6_cambio_e4", 8'(bus.cambio_dir), 8'd0);

    // Pause press landing on a step edge: step still fires, pause toggles
    ticks(3);
    bus.boton_pres = 3'd5;
    tick();
    check("sim_paso",  8'(bus.paso),    8'd1);
    check("sim_pausa", 8'(bus.pausado), 8'd1);
    bus.boton_pres = 3'd0;
    ticks(2);
    check("sim_hold_paso",  8'(bus.paso),    8'd0);
    check("sim_hold_pausa", 8'(bus.pausado), 8'd1);
    bus.boton_pres = 3'd5;
    tick();
    check("sim_unpause", 8'(bus.pausado), 8'd0);
    bus.boton_pres = 3'd0;
    ticks(3);
    check("sim_paso_pre", 8'(bus.paso), 8'd0);
    tick();
    check("sim_paso_resume", 8'(bus.paso), 8'd1);

    // Direction press landing on a step edge: old dir_pend applied first
    ticks(3);
    bus.boton_pres = 3'd1;
    tick();
    check("sde_paso",   8'(bus.paso),       8'd1);
    check("sde_dir",    8'(bus.direccion),  8'd4);
    check("sde_cambio", 8'(bus.cambio_dir), 8'd0);
    bus.boton_pres = 3'd0;
    ticks(4);
    check("sde_paso2",   8'(bus.paso),       8'd1);
    check("sde_dir2",    8'(bus.direccion),  8'd1);
    check("sde_cambio2", 8'(bus.cambio_dir), 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the bench always ends
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
